wisc_instr_encoder: RTL and testbench

Sequential WISC-S25 instruction encoder and program loader. It accepts decoded instruction requests (opcode plus operand fields) over a valid/ready handshake and packs them into 16-bit WISC-S25 words. Words are buffered in a small FIFO and written to consecutive even addresses of instruction memory. It is the inverse of the core's control decoder and is used by the boot/test loader to populate instruction memory before the core runs.

---
 rtl/wisc_instr_encoder.sv | 165 ++++++++++++++++
 tb/tb_wisc_instr_encoder.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wisc_instr_encoder.sv
// wisc_instr_encoder
//   Packs decoded WISC-S25 instruction requests into 16-bit words, buffers
//   them in a small FIFO and writes them to consecutive even addresses of
//   instruction memory. Used by the boot/test loader before the core runs.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   start               begin a program load (honoured in IDLE or DONE only)
//   in_valid/in_ready   request handshake; in_op/rd/rs/rt/imm/cond = fields
//   mem_addr/mem_wdata  write address / encoded word (wdata is 0 when idle)
//   mem_we/mem_ready    memory write handshake
//   enc_err             one-cycle pulse after an illegal request is dropped
//   addr_wrap           sticky: write address wrapped past the top
//   busy/done           state is LOAD or DRAIN / state is DONE
//   dbg_state           current FSM state (IDLE=0, LOAD=1, DRAIN=2, DONE=3)
//
// Handshakes: a transfer happens on a rising edge where valid & ready are
// both high. Once mem_we is raised, mem_addr and mem_wdata hold until
// mem_ready accepts the word; in_ready never depends on a same-cycle pop.
module wisc_instr_encoder #(
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int BASE_ADDR  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [3:0]        in_rd,
    input  logic [3:0]        in_rs,
    input  logic [3:0]        in_rt,
    input  logic [8:0]        in_imm,
    input  logic [2:0]        in_cond,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic              enc_err,
    output logic              addr_wrap,
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] ADDR_LAST = {{(ADDR_W-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               wrap_q, wrap_d;
    logic               enc_err_q;
    logic [15:0]        fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;

    logic        enc_legal;
    logic [15:0] enc_word;
    logic        fifo_full, fifo_empty;
    logic        accept, push, pop, start_load;

    // Encoder: the inverse of the core's control decoder.
    always_comb begin
        enc_legal = 1'b1;
        enc_word  = 16'h0000;
        case (in_op)
            4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111:
                enc_word = {in_op, in_rd, in_rs, in_rt};
            4'b0100, 4'b0101, 4'b0110: begin
                enc_word  = {in_op, in_rd, in_rs, in_imm[3:0]};
                enc_legal = (in_imm[8:4] == 5'b0);
            end
            4'b1000, 4'b1001: begin
                // Word offset: must be even and fit a 5-bit signed byte offset.
                enc_word  = {in_op, in_rd, in_rs, in_imm[4:1]};
                enc_legal = !in_imm[0] && (in_imm[8:5] == {4{in_imm[4]}});
            end
            4'b1010, 4'b1011: begin
                enc_word  = {in_op, in_rd, in_imm[7:0]};
                enc_legal = !in_imm[8];
            end
            4'b1100: enc_word = {in_op, in_cond, in_imm};
            4'b1101: enc_word = {in_op, in_cond, 1'b0, in_rs, 4'b0000};
            4'b1110: enc_word = {in_op, in_rd, 8'h00};
            default: enc_word = 16'hF000;
        endcase
    end

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);

    assign in_ready   = (state_q == S_LOAD) && !fifo_full;
    assign accept     = in_valid && in_ready;
    assign push       = accept && enc_legal;
    assign mem_we     = ((state_q == S_LOAD) || (state_q == S_DRAIN)) && !fifo_empty;
    assign pop        = mem_we && mem_ready;
    assign start_load = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wrap_d  = wrap_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_LOAD;
            S_LOAD:         if (accept && (in_op == 4'hF)) state_d = S_DRAIN;
            // Leave as soon as the last word is accepted so done follows it directly.
            S_DRAIN:        if (count_d == '0) state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase
        if (start_load) begin
            addr_d = ADDR_W'(BASE_ADDR);
            wrap_d = 1'b0;
        end else if (pop) begin
            addr_d = addr_q + ADDR_W'(2);
            if (addr_q == ADDR_LAST) wrap_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= ADDR_W'(BASE_ADDR);
            wrap_q    <= 1'b0;
            enc_err_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wrap_q    <= wrap_d;
            enc_err_q <= accept && !enc_legal;
            count_q   <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= enc_word;
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = mem_we ? fifo_q[rd_ptr_q] : 16'h0000;
    assign enc_err   = enc_err_q;
    assign addr_wrap = wrap_q;
    assign busy      = (state_q == S_LOAD) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_wisc_instr_encoder.sv
module tb_wisc_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n, start, in_valid, mem_ready;
    logic [3:0]  in_op, in_rd, in_rs, in_rt;
    logic [8:0]  in_imm;
    logic [2:0]  in_cond;

    logic        in_ready, mem_we, enc_err, addr_wrap, busy, done;
    logic [15:0] mem_addr, mem_wdata;
    logic [1:0]  dbg_state;

    logic        s_in_ready, s_mem_we, s_enc_err, s_addr_wrap, s_busy, s_done;
    logic [3:0]  s_mem_addr;
    logic [15:0] s_mem_wdata;
    logic [1:0]  s_dbg_state;

    wisc_instr_encoder #(.ADDR_W(16), .FIFO_DEPTH(4), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
        .in_cond(in_cond), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_ready(mem_ready), .enc_err(enc_err), .addr_wrap(addr_wrap), .busy(busy),
        .done(done), .dbg_state(dbg_state)
    );

    // Narrow-address copy, fed the same stimulus, for the wrap-around case.
    wisc_instr_encoder #(.ADDR_W(4), .FIFO_DEPTH(4), .BASE_ADDR(0)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
        .in_cond(in_cond), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_we(s_mem_we),
        .mem_ready(mem_ready), .enc_err(s_enc_err), .addr_wrap(s_addr_wrap), .busy(s_busy),
        .done(s_done), .dbg_state(s_dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Works on the signed immediate value and field positions arithmetically.
    function automatic void ref_encode(input logic [3:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs, input logic [3:0] rt,
                                       input logic [8:0] imm, input logic [2:0] cond,
                                       output bit legal, output logic [15:0] word);
        int o, d, s, t, c, simm, f;
        o = int'(op); d = int'(rd); s = int'(rs); t = int'(rt); c = int'(cond);
        simm = (int'(imm) >= 256) ? int'(imm) - 512 : int'(imm);
        legal = 1'b1;
        f = 0;
        case (o)
            0, 1, 2, 3, 7: f = o * 4096 + d * 256 + s * 16 + t;
            4, 5, 6: begin
                if (simm < 0 || simm > 15) legal = 1'b0;
                else f = o * 4096 + d * 256 + s * 16 + simm;
            end
            8, 9: begin
                if (simm < -16 || simm > 14 || (simm % 2) != 0) legal = 1'b0;
                else f = o * 4096 + d * 256 + s * 16 + ((simm / 2) & 15);
            end
            10, 11: begin
                if (simm < 0) legal = 1'b0;
                else f = o * 4096 + d * 256 + simm;
            end
            12: f = o * 4096 + c * 512 + (simm & 511);
            13: f = o * 4096 + c * 512 + s * 16;
            14: f = o * 4096 + d * 256;
            default: f = 16'hF000;
        endcase
        word = legal ? 16'(f) : 16'h0000;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic [15:0] exp_q[$];
    int          exp_addr = 0;
    bit          err_pend = 1'b0;
    bit          hlt_pend = 1'b0;
    bit          mon_en   = 1'b0;
    bit          m_legal;
    logic [15:0] m_word, m_head;

    always @(negedge clk) begin
        if (!rst_n || !mon_en) begin
            err_pend = 1'b0;
            hlt_pend = 1'b0;
        end else begin
            check("enc_err", {31'b0, enc_err}, {31'b0, err_pend});
            check("s_enc_err", {31'b0, s_enc_err}, {31'b0, err_pend});
            err_pend = 1'b0;
            if (hlt_pend) begin
                check("done_after_hlt", {31'b0, done}, 32'd1);
                hlt_pend = 1'b0;
            end
            if (mem_we && mem_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    m_head = exp_q.pop_front();
                    check("wdata", {16'b0, mem_wdata}, {16'b0, m_head});
                    check("waddr", {16'b0, mem_addr}, exp_addr);
                    check("s_we", {31'b0, s_mem_we}, 32'd1);
                    check("s_wdata", {16'b0, s_mem_wdata}, {16'b0, m_head});
                    check("s_waddr", {28'b0, s_mem_addr}, exp_addr % 16);
                    exp_addr = (exp_addr + 2) % 65536;
                    if (m_head == 16'hF000) hlt_pend = 1'b1;
                end
            end
            if (in_valid && in_ready) begin
                ref_encode(in_op, in_rd, in_rs, in_rt, in_imm, in_cond, m_legal, m_word);
                if (m_legal) exp_q.push_back(m_word);
                else err_pend = 1'b1;
            end
        end
    end

    // Random memory back-pressure while enabled.
    bit rand_ready = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) mem_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- driver tasks (all return at posedge + 1) ----------------
    task automatic send_req(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                            input logic [3:0] rt, input logic [8:0] imm, input logic [2:0] cond);
        bit ok;
        in_op = op; in_rd = rd; in_rs = rs; in_rt = rt; in_imm = imm; in_cond = cond;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        exp_addr = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("start_in_ready", {31'b0, in_ready}, 32'd1);
        check("start_busy", {31'b0, busy}, 32'd1);
        check("start_addr", {16'b0, mem_addr}, 32'd0);
        check("start_wrap", {31'b0, s_addr_wrap}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        check("drain_empty", exp_q.size(), 32'd0);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]  op, rd, rs, rt;
        logic [8:0]  imm;
        logic [2:0]  cond;
        bit          legal;
        logic [15:0] word;
    } vec_t;

    vec_t tbl[16];
    int   tbl_addr;

    initial begin
        //               op     rd     rs     rt     imm      cond  legal word
        tbl[0]  = '{4'h0, 4'h1, 4'h2, 4'h3, 9'h000, 3'd0, 1, 16'h0123}; // ADD
        tbl[1]  = '{4'hA, 4'h7, 4'h0, 4'h0, 9'h0A5, 3'd0, 1, 16'hA7A5}; // LLB
        tbl[2]  = '{4'h8, 4'h4, 4'h5, 4'h0, 9'h1FC, 3'd0, 1, 16'h845E}; // LW -4
        tbl[3]  = '{4'h9, 4'h4, 4'h5, 4'h0, 9'h003, 3'd0, 0, 16'h0000}; // SW odd
        tbl[4]  = '{4'hC, 4'h0, 4'h0, 4'h0, 9'h1FE, 3'd2, 1, 16'hC5FE}; // B -2
        tbl[5]  = '{4'hD, 4'h0, 4'h9, 4'h0, 9'h000, 3'd7, 1, 16'hDE90}; // BR
        tbl[6]  = '{4'hE, 4'h3, 4'h0, 4'h0, 9'h000, 3'd0, 1, 16'hE300}; // PCS
        tbl[7]  = '{4'h4, 4'h2, 4'h3, 4'h9, 9'h00F, 3'd0, 1, 16'h423F}; // shift 15
        tbl[8]  = '{4'h5, 4'h2, 4'h3, 4'h0, 9'h010, 3'd0, 0, 16'h0000}; // shift 16
        tbl[9]  = '{4'h8, 4'h1, 4'h2, 4'h0, 9'h00E, 3'd0, 1, 16'h8127}; // LW +14
        tbl[10] = '{4'h9, 4'h1, 4'h2, 4'h0, 9'h1F0, 3'd0, 1, 16'h9128}; // SW -16
        tbl[11] = '{4'h8, 4'h1, 4'h2, 4'h0, 9'h1EE, 3'd0, 0, 16'h0000}; // LW -18
        tbl[12] = '{4'h8, 4'h1, 4'h2, 4'h0, 9'h010, 3'd0, 0, 16'h0000}; // LW +16
        tbl[13] = '{4'hB, 4'h5, 4'h0, 4'h0, 9'h0FF, 3'd0, 1, 16'hB5FF}; // LHB 255
        tbl[14] = '{4'hA, 4'h5, 4'h0, 4'h0, 9'h100, 3'd0, 0, 16'h0000}; // LLB imm[8]
        tbl[15] = '{4'h7, 4'hF, 4'hE, 4'hD, 9'h000, 3'd0, 1, 16'h7FED}; // R-type

        // ---------- reset ----------
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; mem_ready = 1'b0;
        in_op = '0; in_rd = '0; in_rs = '0; in_rt = '0; in_imm = '0; in_cond = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_wdata", {16'b0, mem_wdata}, 32'd0);
        check("rst_addr", {16'b0, mem_addr}, 32'd0);
        check("rst_enc_err", {31'b0, enc_err}, 32'd0);
        check("rst_wrap", {31'b0, addr_wrap}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_state", {30'b0, dbg_state}, 32'd0);
        check("rst_s_state", {30'b0, s_dbg_state}, 32'd0);
        check("rst_s_ready", {31'b0, s_in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;

        // ---------- table vectors: one request, check next cycle ----------
        do_start();
        tbl_addr = 0;
        for (int i = 0; i < 16; i++) begin
            send_req(tbl[i].op, tbl[i].rd, tbl[i].rs, tbl[i].rt, tbl[i].imm, tbl[i].cond);
            @(negedge clk);
            check($sformatf("tbl%0d_we", i), {31'b0, mem_we}, {31'b0, tbl[i].legal});
            check($sformatf("tbl%0d_err", i), {31'b0, enc_err}, {31'b0, !tbl[i].legal});
            check($sformatf("tbl%0d_addr", i), {16'b0, mem_addr}, tbl_addr);
            if (tbl[i].legal) begin
                check($sformatf("tbl%0d_wdata", i), {16'b0, mem_wdata}, {16'b0, tbl[i].word});
                tbl_addr += 2;
            end
            @(posedge clk);
            #1;
        end

        // ---------- back-pressure: FIFO fills after four accepts ----------
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send_req(4'h1, 4'(i), 4'(i + 1), 4'(i + 2), 9'h000, 3'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("full_in_ready", {31'b0, in_ready}, 32'd0);
            check("hold_we", {31'b0, mem_we}, 32'd1);
            check("hold_addr", {16'b0, mem_addr}, tbl_addr);
            check("hold_wdata", {16'b0, mem_wdata}, {16'b0, exp_q[0]});
        end
        @(posedge clk);
        #1;
        in_op = 4'h2; in_rd = 4'h9; in_rs = 4'h8; in_rt = 4'h7; in_valid = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        check("no_bypass", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        send_req(4'h2, 4'h9, 4'h8, 4'h7, 9'h000, 3'd0);
        wait_drain();

        // ---------- randomized traffic against the model ----------
        rand_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            logic [8:0] r_imm;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            if ($urandom_range(0, 1) == 1) r_imm = 9'($urandom_range(0, 511));
            else r_imm = 9'($urandom_range(0, 31) - 16);
            send_req(4'($urandom_range(0, 14)), 4'($urandom), 4'($urandom), 4'($urandom),
                     r_imm, 3'($urandom));
        end
        rand_ready = 1'b0;
        mem_ready = 1'b1;

        // ---------- HLT, drain, DONE, ignore requests, restart ----------
        send_req(4'hF, 4'h0, 4'h0, 4'h0, 9'h000, 3'd0);
        wait_drain();
        @(negedge clk);
        check("hlt_done", {31'b0, done}, 32'd1);
        check("hlt_busy", {31'b0, busy}, 32'd0);
        check("hlt_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        in_op = 4'h0; in_rd = 4'h1; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("done_ignore_ready", {31'b0, in_ready}, 32'd0);
            check("done_ignore_we", {31'b0, mem_we}, 32'd0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        do_start();

        // ---------- 4-bit address wrap ----------
        for (int i = 0; i < 9; i++) begin
            send_req(4'h3, 4'($urandom), 4'($urandom), 4'($urandom), 9'h000, 3'd0);
            @(posedge clk);
            #1;
            if (i == 6) begin
                @(negedge clk);
                check("pre_wrap_flag", {31'b0, s_addr_wrap}, 32'd0);
                check("pre_wrap_addr", {28'b0, s_mem_addr}, 32'd14);
                @(posedge clk);
                #1;
            end
            if (i == 7) begin
                @(negedge clk);
                check("wrap_flag", {31'b0, s_addr_wrap}, 32'd1);
                check("wrap_addr", {28'b0, s_mem_addr}, 32'd0);
                check("wide_no_wrap", {31'b0, addr_wrap}, 32'd0);
                check("wide_addr", {16'b0, mem_addr}, 32'd16);
                @(posedge clk);
                #1;
            end
        end
        @(negedge clk);
        check("post_wrap_addr", {28'b0, s_mem_addr}, 32'd2);
        check("wrap_sticky", {31'b0, s_addr_wrap}, 32'd1);
        @(posedge clk);
        #1;

        // ---------- asynchronous reset in the middle of DRAIN ----------
        mem_ready = 1'b0;
        send_req(4'h0, 4'h1, 4'h1, 4'h1, 9'h000, 3'd0);
        send_req(4'h1, 4'h2, 4'h2, 4'h2, 9'h000, 3'd0);
        send_req(4'hF, 4'h0, 4'h0, 4'h0, 9'h000, 3'd0);
        @(negedge clk);
        check("drain_busy", {31'b0, busy}, 32'd1);
        check("drain_we", {31'b0, mem_we}, 32'd1);
        check("drain_in_ready", {31'b0, in_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        mon_en = 1'b0;
        exp_q.delete();
        #1;
        check("arst_we", {31'b0, mem_we}, 32'd0);
        check("arst_wdata", {16'b0, mem_wdata}, 32'd0);
        check("arst_done", {31'b0, done}, 32'd0);
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_s_we", {31'b0, s_mem_we}, 32'd0);
        check("arst_s_done", {31'b0, s_done}, 32'd0);
        check("arst_s_busy", {31'b0, s_busy}, 32'd0);
        check("arst_s_wrap", {31'b0, s_addr_wrap}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        check("post_rst_we", {31'b0, mem_we}, 32'd0);
        check("post_rst_done", {31'b0, done}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
